pwm_poly_synth: RTL

- Parametrised successor to the single-voice PWM audio generator.
- Contains NUM_VOICES independent square-wave oscillators, each with its own ADSR envelope FSM, retrigger and loop control.
- Voice samples are averaged into one duty value that drives a complementary PWM pin pair.
- Sits inside the user wrapper; control inputs come straight from GPIO pads.

---
 rtl/pwm_poly_synth.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/pwm_poly_synth.sv
// rtl/pwm_poly_synth.sv - polyphonic square-wave synth with per-voice ADSR envelopes and complementary PWM output
// Optional build macro: PWM_POLY_SYNTH_STATUS_EN adds the registered voice_active status output.
module pwm_poly_synth #(
  parameter int NUM_VOICES = 2,
  parameter int FREQ_W     = 12,
  parameter int ACC_W      = 16,
  parameter int ENV_W      = 8,
  parameter int PRESC      = 256,
  parameter int SUS_UNIT   = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_VOICES*FREQ_W-1:0] freq,
  input  logic [NUM_VOICES-1:0]        trigger,
  input  logic                         loop,
  input  logic                         adsr_switch,
  input  logic [2:0]                   adsr_choice,
  input  logic [2:0]                   note_length,
`ifdef PWM_POLY_SYNTH_STATUS_EN
  output logic [NUM_VOICES-1:0]        voice_active,
`endif
  output logic                         pwm_out,
  output logic                         pwm_out_n
);

  localparam int LOG2_NV = $clog2(NUM_VOICES);
  localparam int SUM_W   = ENV_W + LOG2_NV;
  localparam int PRE_W   = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int SUS_W   = $clog2(8 * SUS_UNIT + 1);

  localparam logic [ENV_W-1:0] ENV_MAX = {ENV_W{1'b1}};
  localparam logic [ENV_W-1:0] SUS_LVL = ENV_W'(1) << (ENV_W - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ATTACK  = 3'd1;
  localparam logic [2:0] S_DECAY   = 3'd2;
  localparam logic [2:0] S_SUSTAIN = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  // One extra bit so envelope arithmetic can see past ENV_MAX before clamping
  typedef logic [ENV_W:0] ext_t;

  logic [NUM_VOICES-1:0] trig_s1, trig_s2, trig_s3, trig_pulse;
  logic [PRE_W-1:0]      presc_cnt;
  logic                  env_tick;
  logic [ACC_W-1:0]      phase   [NUM_VOICES];
  logic [2:0]            state   [NUM_VOICES];
  logic [ENV_W-1:0]      env     [NUM_VOICES];
  logic [SUS_W-1:0]      sus_cnt [NUM_VOICES];
  logic [ENV_W-1:0]      sample  [NUM_VOICES];
  ext_t                  atk_step, dec_step;
  logic [SUS_W-1:0]      sus_target;
  logic [SUM_W-1:0]      sum;
  logic [ENV_W-1:0]      mix, pcnt, duty;

  // Pad triggers: two flops against metastability, a third to find the rising edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trig_s1 <= '0;
      trig_s2 <= '0;
      trig_s3 <= '0;
    end else begin
      trig_s1 <= trigger;
      trig_s2 <= trig_s1;
      trig_s3 <= trig_s2;
    end
  end

  assign trig_pulse = trig_s2 & ~trig_s3;

  // Shared envelope prescaler; env_tick marks the last count of each period
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) presc_cnt <= '0;
    else if (env_tick) presc_cnt <= '0;
    else presc_cnt <= presc_cnt + 1'b1;
  end

  assign env_tick = (presc_cnt == PRE_W'(PRESC - 1));

  // Phase accumulators; the MSB is the square wave
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VOICES; v++) phase[v] <= '0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++)
        phase[v] <= phase[v] + ACC_W'(freq[v*FREQ_W +: FREQ_W]);
    end
  end

  assign atk_step   = ext_t'(1) << adsr_choice[1:0];
  assign dec_step   = adsr_choice[2] ? ext_t'(4) : ext_t'(1);
  assign sus_target = SUS_W'((32'(note_length) + 1) * SUS_UNIT);

  // Per-voice ADSR; a trigger restarts ATTACK from the present level and beats a same-cycle tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        state[v]   <= S_IDLE;
        env[v]     <= '0;
        sus_cnt[v] <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (trig_pulse[v]) begin
          state[v]   <= S_ATTACK;
          sus_cnt[v] <= '0;
        end else if (env_tick) begin
          case (state[v])
            S_IDLE: env[v] <= '0;
            S_ATTACK:
              if (ext_t'(env[v]) + atk_step >= ext_t'(ENV_MAX)) begin
                env[v]   <= ENV_MAX;
                state[v] <= S_DECAY;
              end else begin
                env[v] <= env[v] + atk_step[ENV_W-1:0];
              end
            S_DECAY:
              if (ext_t'(env[v]) <= ext_t'(SUS_LVL) + dec_step) begin
                env[v]     <= SUS_LVL;
                state[v]   <= S_SUSTAIN;
                sus_cnt[v] <= '0;
              end else begin
                env[v] <= env[v] - dec_step[ENV_W-1:0];
              end
            S_SUSTAIN:
              if (sus_cnt[v] + 1'b1 >= sus_target) begin
                state[v]   <= S_RELEASE;
                sus_cnt[v] <= '0;
              end else begin
                sus_cnt[v] <= sus_cnt[v] + 1'b1;
              end
            S_RELEASE:
              if (ext_t'(env[v]) <= dec_step) begin
                env[v]   <= '0;
                state[v] <= loop ? S_ATTACK : S_IDLE;
              end else begin
                env[v] <= env[v] - dec_step[ENV_W-1:0];
              end
            default: begin
              env[v]   <= '0;
              state[v] <= S_IDLE;
            end
          endcase
        end
      end
    end
  end

  // Gate each voice's amplitude by its square wave and average the voices
  always_comb begin
    sum = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!phase[v][ACC_W-1]) sample[v] = '0;
      else if (adsr_switch) sample[v] = env[v];
      else sample[v] = (state[v] != S_IDLE) ? ENV_MAX : '0;
      sum = sum + SUM_W'(sample[v]);
    end
  end

  assign mix = ENV_W'(sum >> LOG2_NV);

  // PWM: duty only reloads at the period boundary so a mid-period mix change cannot glitch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt      <= '0;
      duty      <= '0;
      pwm_out   <= 1'b0;
      pwm_out_n <= 1'b1;
    end else begin
      pcnt      <= pcnt + 1'b1;
      if (pcnt == ENV_MAX) duty <= mix;
      pwm_out   <= (pcnt < duty);
      pwm_out_n <= !(pcnt < duty);
    end
  end

`ifdef PWM_POLY_SYNTH_STATUS_EN
  // Registered per-voice busy flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) voice_active <= '0;
    else for (int v = 0; v < NUM_VOICES; v++) voice_active[v] <= (state[v] != S_IDLE);
  end
`endif

endmodule
